// File: rtl/sha256_round_engine_if.sv
// ---------------------------------------------------------------------------
// sha256_round_engine_if
// Bundles the control/data signals between the SHA-256 round engine and its
// surroundings (host feeder plus message-schedule block).
//   msg_init     : pulse, start a new message (reload H_INIT)
//   chunk_start  : pulse, schedule block holds W0..W15, begin compression
//   w_t          : current schedule word (schedule block's w_out)
//   sched_adv    : advance the schedule block (its proc_ninit)
//   sched_clear  : clear the schedule block
//   busy         : compression in progress
//   chunk_done   : one-cycle pulse after H is updated
//   digest       : H0..H7, H0 in [255:224]
//   digest_valid : digest holds the result of at least one completed chunk
// Modports: master = host/schedule side, slave = round engine.
// ---------------------------------------------------------------------------
interface sha256_round_engine_if;
    logic           msg_init;
    logic           chunk_start;
    logic [31:0]    w_t;
    logic           sched_adv;
    logic           sched_clear;
    logic           busy;
    logic           chunk_done;
    logic [255:0]   digest;
    logic           digest_valid;

    modport master (
        output msg_init, chunk_start, w_t,
        input  sched_adv, sched_clear, busy, chunk_done, digest, digest_valid
    );

    modport slave (
        input  msg_init, chunk_start, w_t,
        output sched_adv, sched_clear, busy, chunk_done, digest, digest_valid
    );
endinterface

// File: rtl/sha256_round_engine.sv
// ---------------------------------------------------------------------------
// sha256_round_engine
// SHA-256 compression core. Consumes one schedule word per round cycle from
// the message-schedule block, runs 64 rounds per 512-bit chunk and folds the
// result into the running hash H0..H7.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sha256_round_engine_if.slave (see interface file for signals)
// Parameter:
//   H_INIT : initial hash value, H0 in [255:224], H7 in [31:0]
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for msg_init / chunk_start, H holds current digest
// S_ROUND | running round r_t (0..63), schedule block advancing
// S_FINAL | adding working variables into H, clearing schedule block
// ---------------------------------------------------------------------------
module sha256_round_engine #(
    parameter logic [255:0] H_INIT =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_round_engine_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [1:0]  r_state;
    logic [5:0]  r_t;
    logic [31:0] r_hash [8];
    logic [31:0] r_var  [8];   // a..h in indices 0..7
    logic        r_chunk_done;
    logic        r_digest_valid;

    logic [31:0] w_hinit [8];
    logic [31:0] w_s0;
    logic [31:0] w_s1;
    logic [31:0] w_ch;
    logic [31:0] w_maj;
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic        w_abort;

    for (genvar g = 0; g < 8; g++) begin : g_hinit
        assign w_hinit[g] = H_INIT[255 - 32*g -: 32];
    end

    always_comb begin
        w_s1  = rotr(r_var[4], 6) ^ rotr(r_var[4], 11) ^ rotr(r_var[4], 25);
        w_s0  = rotr(r_var[0], 2) ^ rotr(r_var[0], 13) ^ rotr(r_var[0], 22);
        w_ch  = (r_var[4] & r_var[5]) ^ (~r_var[4] & r_var[6]);
        w_maj = (r_var[0] & r_var[1]) ^ (r_var[0] & r_var[2]) ^ (r_var[1] & r_var[2]);
        w_t1  = r_var[7] + w_s1 + w_ch + K[r_t] + bus.w_t;
        w_t2  = w_s0 + w_maj;
    end

    // msg_init while a chunk is in flight abandons it outright
    assign w_abort = bus.msg_init && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_t            <= 6'd0;
            r_chunk_done   <= 1'b0;
            r_digest_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_hash[i] <= w_hinit[i];
                r_var[i]  <= 32'd0;
            end
        end else begin
            r_chunk_done <= 1'b0;
            if (w_abort) begin
                r_state        <= S_IDLE;
                r_digest_valid <= 1'b0;
                for (int i = 0; i < 8; i++) r_hash[i] <= w_hinit[i];
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.msg_init) begin
                            r_digest_valid <= 1'b0;
                            for (int i = 0; i < 8; i++) r_hash[i] <= w_hinit[i];
                        end
                        if (bus.chunk_start) begin
                            r_state        <= S_ROUND;
                            r_t            <= 6'd0;
                            r_digest_valid <= 1'b0;
                            // same-cycle msg_init wins: start from the IV
                            for (int i = 0; i < 8; i++)
                                r_var[i] <= bus.msg_init ? w_hinit[i] : r_hash[i];
                        end
                    end
                    S_ROUND: begin
                        r_var[7] <= r_var[6];
                        r_var[6] <= r_var[5];
                        r_var[5] <= r_var[4];
                        r_var[4] <= r_var[3] + w_t1;
                        r_var[3] <= r_var[2];
                        r_var[2] <= r_var[1];
                        r_var[1] <= r_var[0];
                        r_var[0] <= w_t1 + w_t2;
                        r_t      <= r_t + 6'd1;
                        if (r_t == 6'd63) r_state <= S_FINAL;
                    end
                    S_FINAL: begin
                        for (int i = 0; i < 8; i++) r_hash[i] <= r_hash[i] + r_var[i];
                        r_chunk_done   <= 1'b1;
                        r_digest_valid <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sched_adv    = (r_state == S_ROUND);
    assign bus.sched_clear  = (r_state == S_FINAL) || w_abort;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.chunk_done   = r_chunk_done;
    assign bus.digest_valid = r_digest_valid;
    assign bus.digest       = {r_hash[0], r_hash[1], r_hash[2], r_hash[3],
                               r_hash[4], r_hash[5], r_hash[6], r_hash[7]};

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;

    localparam logic [255:0] H_INIT =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_round_engine_if bus_if ();

    sha256_round_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // Schedule block model (sha256_chunk_process): w_out = W[0]
    logic [31:0]  sch [16];
    logic         sch_load;
    logic [511:0] load_vec;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    always @(posedge clk) begin
        if (sch_load) begin
            for (int i = 0; i < 16; i++) sch[i] <= load_vec[511 - 32*i -: 32];
        end else if (bus_if.sched_clear) begin
            for (int i = 0; i < 16; i++) sch[i] <= 32'd0;
        end else if (bus_if.sched_adv) begin
            for (int i = 0; i < 15; i++) sch[i] <= sch[i+1];
            sch[15] <= sig1(sch[14]) + sch[9] + sig0(sch[1]) + sch[0];
        end
    end

    assign bus_if.w_t = sch[0];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic do_msg_init();
        @(negedge clk); bus_if.msg_init = 1'b1;
        @(negedge clk); bus_if.msg_init = 1'b0;
    endtask

    // Loads a block, pulses chunk_start (optionally with msg_init) and watches
    // up to 75 cycles. Cycle n=1 is the cycle after chunk_start was sampled.
    // inj_kind: 0 none, 1 chunk_start, 2 msg_init, 3 rst, injected at cycle inj_n.
    task automatic run_chunk(input logic [511:0] blk, input bit with_init,
                             input int inj_kind, input int inj_n,
                             output int lat, output int adv_n,
                             output int clr_n, output int dv_n);
        lat = -1; adv_n = 0; clr_n = 0; dv_n = 0;
        @(negedge clk); load_vec = blk; sch_load = 1'b1;
        @(negedge clk); sch_load = 1'b0; bus_if.chunk_start = 1'b1;
        if (with_init) bus_if.msg_init = 1'b1;
        for (int n = 1; n <= 75; n++) begin
            @(negedge clk);
            bus_if.chunk_start = 1'b0;
            bus_if.msg_init    = 1'b0;
            rst                = 1'b0;
            if (bus_if.chunk_done) begin
                lat = n;
                break;
            end
            adv_n += int'(bus_if.sched_adv);
            clr_n += int'(bus_if.sched_clear);
            dv_n  += int'(bus_if.digest_valid);
            if (n == inj_n) begin
                case (inj_kind)
                    1: bus_if.chunk_start = 1'b1;
                    2: begin
                        bus_if.msg_init = 1'b1;
                        #1;
                        check_val("abort_clear_pulse", bus_if.sched_clear, 1);
                    end
                    3: begin
                        rst = 1'b1;
                        #1;
                        check_val("rst_mid_adv",   bus_if.sched_adv, 0);
                        check_val("rst_mid_clr",   bus_if.sched_clear, 0);
                        check_val("rst_mid_busy",  bus_if.busy, 0);
                        check_val("rst_mid_done",  bus_if.chunk_done, 0);
                        check_val("rst_mid_valid", bus_if.digest_valid, 0);
                        check_val("rst_mid_digest", bus_if.digest, H_INIT);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    int lat, adv, clr, dv;

    initial begin
        rst = 1'b1;
        sch_load = 1'b0;
        load_vec = '0;
        bus_if.msg_init = 1'b0;
        bus_if.chunk_start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_adv",    bus_if.sched_adv, 0);
        check_val("reset_clr",    bus_if.sched_clear, 0);
        check_val("reset_busy",   bus_if.busy, 0);
        check_val("reset_done",   bus_if.chunk_done, 0);
        check_val("reset_valid",  bus_if.digest_valid, 0);
        check_val("reset_digest", bus_if.digest, H_INIT);
        rst = 1'b0;

        // "abc"
        do_msg_init();
        run_chunk(B_ABC, 1'b0, 0, 0, lat, adv, clr, dv);
        check_val("abc_latency",   lat, 66);
        check_val("abc_adv_count", adv, 64);
        check_val("abc_clr_count", clr, 1);
        check_val("abc_valid_low_during", dv, 0);
        check_val("abc_digest",    bus_if.digest, D_ABC);
        check_val("abc_valid",     bus_if.digest_valid, 1);
        @(negedge clk);
        check_val("abc_done_width", bus_if.chunk_done, 0);
        check_val("abc_busy_after", bus_if.busy, 0);

        // empty message
        do_msg_init();
        check_val("init_digest", bus_if.digest, H_INIT);
        check_val("init_valid",  bus_if.digest_valid, 0);
        run_chunk(B_EMPTY, 1'b0, 0, 0, lat, adv, clr, dv);
        check_val("empty_latency", lat, 66);
        check_val("empty_digest",  bus_if.digest, D_EMPTY);

        // two-block message, second chunk straight after the first chunk_done
        do_msg_init();
        run_chunk(B_TWO1, 1'b0, 0, 0, lat, adv, clr, dv);
        check_val("two1_latency", lat, 66);
        run_chunk(B_TWO2, 1'b0, 0, 0, lat, adv, clr, dv);
        check_val("two2_latency", lat, 66);
        check_val("two2_valid_low_during", dv, 0);
        check_val("two_digest",   bus_if.digest, D_TWO);
        check_val("two_valid",    bus_if.digest_valid, 1);

        // chunk_start at round 10 is ignored
        do_msg_init();
        run_chunk(B_ABC, 1'b0, 1, 11, lat, adv, clr, dv);
        check_val("cs_busy_latency", lat, 66);
        check_val("cs_busy_adv",     adv, 64);
        check_val("cs_busy_digest",  bus_if.digest, D_ABC);

        // msg_init at round 30 aborts
        do_msg_init();
        run_chunk(B_ABC, 1'b0, 2, 31, lat, adv, clr, dv);
        check_val("abort_no_done", lat, -1);
        check_val("abort_busy",    bus_if.busy, 0);
        check_val("abort_digest",  bus_if.digest, H_INIT);
        check_val("abort_valid",   bus_if.digest_valid, 0);
        run_chunk(B_ABC, 1'b0, 0, 0, lat, adv, clr, dv);
        check_val("post_abort_latency", lat, 66);
        check_val("post_abort_digest",  bus_if.digest, D_ABC);

        // rst at round 40, then msg_init + chunk_start together
        do_msg_init();
        run_chunk(B_ABC, 1'b0, 3, 41, lat, adv, clr, dv);
        check_val("rst_no_done", lat, -1);
        run_chunk(B_ABC, 1'b1, 0, 0, lat, adv, clr, dv);
        check_val("init_start_latency", lat, 66);
        check_val("init_start_digest",  bus_if.digest, D_ABC);
        check_val("init_start_valid",   bus_if.digest_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
